// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared burst types and command legality check for the AXI burst address path.
// Imported by the generator top and by the downstream data-path stage.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_t;

  localparam int BOUNDARY_4K = 4096;

  // addr is zero-extended to 64 bits so one function serves any ADDR_W up to 64.
  function automatic logic cmd_legal(input logic [63:0] addr,
                                     input logic [7:0]  len,
                                     input logic [2:0]  size,
                                     input logic [1:0]  burst,
                                     input int          addr_w,
                                     input int          data_bytes);
    logic [64:0] w_aligned;
    logic [64:0] w_last;
    logic [8:0]  w_beats;
    logic        w_ok;
    w_beats   = {1'b0, len} + 9'd1;
    w_aligned = {1'b0, addr} & ~((65'd1 << size) - 65'd1);
    w_last    = w_aligned + ({56'd0, w_beats} << size) - 65'd1;
    w_ok      = 1'b1;
    if (burst == RSVD)
      w_ok = 1'b0;
    if ((1 << size) > data_bytes)
      w_ok = 1'b0;
    if ((burst == WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      w_ok = 1'b0;
    if ((burst == INCR) &&
        (((w_last >> addr_w) != 65'd0) ||
         ((w_last / BOUNDARY_4K) != (w_aligned / BOUNDARY_4K))))
      w_ok = 1'b0;
    return w_ok;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// Command and per-beat address bundle between the AW/AR capture, the generator
// and the per-beat data stage.
interface axi_burst_addr_gen_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic              beat_valid;
  logic              beat_ready;
  logic [ADDR_W-1:0] beat_addr;
  logic [7:0]        beat_idx;
  logic              beat_last;
  logic              cmd_err;
  logic              busy;

  // master issues commands and consumes beats; slave is the generator
  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_addr, beat_idx, beat_last, cmd_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_addr, beat_idx, beat_last, cmd_err, busy
  );
endinterface

// File: rtl/axi_burst_addr_gen_next_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Shared with the per-beat data/memory model stage.
module axi_burst_next_addr
  import axi_burst_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next_addr
);

  logic [ADDR_W-1:0] w_bytes;
  logic [ADDR_W-1:0] w_aligned;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_wrap_mask;

  assign w_bytes     = ADDR_W'(1) << i_size;
  assign w_aligned   = i_addr & ~(w_bytes - ADDR_W'(1));
  assign w_incr      = w_aligned + w_bytes;
  // Wrap window is (len+1)*B bytes; legal WRAP lengths keep this a power of two.
  assign w_wrap_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);

  always_comb begin
    o_next_addr = i_addr;
    case (i_burst)
      INCR:    o_next_addr = w_incr;
      WRAP:    o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default: o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI4 AW/AR burst command into a per-beat address stream,
// dropping illegal commands with a one-cycle cmd_err pulse.
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  axi_burst_addr_gen_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [7:0]        r_idx;
  logic              r_err;

  logic              w_beat_valid;
  logic              w_beat_last;
  logic              w_cmd_ready;
  logic              w_cmd_hs;
  logic              w_beat_hs;
  logic              w_legal;
  logic [ADDR_W-1:0] w_next_addr;

  axi_burst_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  assign w_beat_valid = (r_state == S_BURST);
  assign w_beat_last  = w_beat_valid && (r_idx == r_len);
  assign w_beat_hs    = w_beat_valid && bus.beat_ready;
  // Ready during the last beat handshake lets bursts run back to back.
  assign w_cmd_ready  = !areset && ((r_state == S_IDLE) || (w_beat_hs && w_beat_last));
  assign w_cmd_hs     = bus.cmd_valid && w_cmd_ready;
  assign w_legal      = cmd_legal(64'(bus.cmd_addr), bus.cmd_len, bus.cmd_size,
                                  bus.cmd_burst, ADDR_W, DATA_BYTES);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_cmd_hs && !w_legal;
      if (w_cmd_hs && w_legal) begin
        r_state <= S_BURST;
        r_addr  <= bus.cmd_addr;
        r_len   <= bus.cmd_len;
        r_size  <= bus.cmd_size;
        r_burst <= bus.cmd_burst;
        r_idx   <= 8'd0;
      end else if (w_beat_hs) begin
        if (w_beat_last) begin
          r_state <= S_IDLE;
        end else begin
          r_addr <= w_next_addr;
          r_idx  <= r_idx + 8'd1;
        end
      end
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.beat_valid = w_beat_valid;
  assign bus.beat_addr  = r_addr;
  assign bus.beat_idx   = r_idx;
  assign bus.beat_last  = w_beat_last;
  assign bus.cmd_err    = r_err;
  assign bus.busy       = (r_state == S_BURST);

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen: hand-computed beat addresses for
// FIXED/INCR/WRAP, illegal commands, backpressure, back-to-back and reset.
module tb_axi_burst_addr_gen;
  import axi_burst_pkg::*;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   vectorCount = 0;
  int   missCount = 0;

  axi_burst_addr_gen_if #(.ADDR_W(32)) bus ();

  axi_burst_addr_gen #(.ADDR_W(32), .DATA_BYTES(4)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a command on a falling edge; returns on the falling edge after the handshake.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
    @(negedge aclk);
    checkOutput("cmd_ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_size  = size;
    bus.cmd_burst = burst;
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
  endtask

  // Checks the currently presented beat, then lets one clock edge pass.
  task automatic checkBeat(input logic [31:0] addr, input logic [7:0] idx, input logic last);
    checkOutput("beat_valid", 64'(bus.beat_valid), 64'd1);
    checkOutput("beat_addr", 64'(bus.beat_addr), 64'(addr));
    checkOutput("beat_idx", 64'(bus.beat_idx), 64'(idx));
    checkOutput("beat_last", 64'(bus.beat_last), 64'(last));
    checkOutput("busy", 64'(bus.busy), 64'd1);
    if (bus.beat_ready)
      checkOutput("cmd_ready_in_burst", 64'(bus.cmd_ready), 64'(last));
    @(negedge aclk);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_beat_valid"}, 64'(bus.beat_valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic checkIllegal(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
    applyStimulus(addr, len, size, burst);
    checkOutput("err_pulse", 64'(bus.cmd_err), 64'd1);
    checkOutput("err_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkIdle("err_no_beat");
    @(negedge aclk);
    checkOutput("err_one_cycle", 64'(bus.cmd_err), 64'd0);
    checkIdle("err_after");
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_len    = '0;
    bus.cmd_size   = '0;
    bus.cmd_burst  = '0;
    bus.beat_ready = 1'b1;

    @(negedge aclk);
    checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    checkOutput("rst_cmd_err", 64'(bus.cmd_err), 64'd0);
    checkIdle("rst");
    areset = 1'b0;

    applyStimulus(32'h1002, 8'd3, 3'd2, INCR);
    checkBeat(32'h1002, 8'd0, 1'b0);
    checkBeat(32'h1004, 8'd1, 1'b0);
    checkBeat(32'h1008, 8'd2, 1'b0);
    checkBeat(32'h100C, 8'd3, 1'b1);
    checkIdle("incr_done");

    applyStimulus(32'h1034, 8'd3, 3'd2, WRAP);
    checkBeat(32'h1034, 8'd0, 1'b0);
    checkBeat(32'h1038, 8'd1, 1'b0);
    checkBeat(32'h103C, 8'd2, 1'b0);
    checkBeat(32'h1030, 8'd3, 1'b1);
    checkIdle("wrap_done");

    applyStimulus(32'h200, 8'd2, 3'd1, FIXED);
    checkBeat(32'h200, 8'd0, 1'b0);
    checkBeat(32'h200, 8'd1, 1'b0);
    checkBeat(32'h200, 8'd2, 1'b1);
    checkIdle("fixed_done");

    checkIllegal(32'h0FF8, 8'd3, 3'd2, INCR);
    checkIllegal(32'h1000, 8'd2, 3'd2, WRAP);
    checkIllegal(32'h1000, 8'd0, 3'd3, INCR);
    checkIllegal(32'h1000, 8'd0, 3'd2, RSVD);

    // Ends exactly on 0xFFF, so this one stays legal.
    applyStimulus(32'h0FF0, 8'd3, 3'd2, INCR);
    checkOutput("edge4k_no_err", 64'(bus.cmd_err), 64'd0);
    checkBeat(32'h0FF0, 8'd0, 1'b0);
    checkBeat(32'h0FF4, 8'd1, 1'b0);
    checkBeat(32'h0FF8, 8'd2, 1'b0);
    checkBeat(32'h0FFC, 8'd3, 1'b1);
    checkIdle("edge4k_done");

    bus.beat_ready = 1'b0;
    applyStimulus(32'h80, 8'd1, 3'd2, INCR);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      checkBeat(32'h80, 8'd0, 1'b0);
    end
    bus.beat_ready = 1'b1;
    checkBeat(32'h80, 8'd0, 1'b0);
    checkBeat(32'h84, 8'd1, 1'b1);
    checkIdle("stall_done");

    applyStimulus(32'h100, 8'd1, 3'd2, INCR);
    checkBeat(32'h100, 8'd0, 1'b0);
    checkOutput("b2b_last", 64'(bus.beat_last), 64'd1);
    checkOutput("b2b_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h300;
    bus.cmd_len   = 8'd0;
    bus.cmd_size  = 3'd2;
    bus.cmd_burst = INCR;
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    checkBeat(32'h300, 8'd0, 1'b1);
    checkIdle("b2b_done");

    applyStimulus(32'h2000, 8'd7, 3'd2, INCR);
    checkBeat(32'h2000, 8'd0, 1'b0);
    checkBeat(32'h2004, 8'd1, 1'b0);
    areset = 1'b1;
    #1;
    checkIdle("midrst");
    checkOutput("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checkIdle("postrst");
    checkOutput("postrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    applyStimulus(32'h40, 8'd0, 3'd2, INCR);
    checkBeat(32'h40, 8'd0, 1'b1);
    checkIdle("postrst_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/axi_burst_addr_gen.md
Name: axi_burst_addr_gen

Overview:
Expands one AXI4 AW/AR burst command into a per-beat stream of addresses, with one beat per data transfer. Sits directly downstream of the address-channel capture in the patched AXI VIP slave path. Feeds the per-beat data/memory model stage. Supports FIXED, INCR and WRAP bursts, and rejects illegal commands (reserved burst, oversize, bad WRAP length, 4KB crossing).

Parameters:
ADDR_W, 32, address width in bits (minimum 13)
DATA_BYTES, 4, data bus width in bytes (power of two, 1..128)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_addr  in  ADDR_W  AxADDR
cmd_len  in  8  AxLEN (beats-1)
cmd_size  in  3  AxSIZE (bytes per beat = 1<<size)
cmd_burst  in  2  AxBURST
beat_valid  out  1  beat address valid
beat_ready  in  1  beat consumed
beat_addr  out  ADDR_W  address of current beat
beat_idx  out  8  beat number, 0..len
beat_last  out  1  high on final beat
cmd_err  out  1  one-cycle pulse: illegal command dropped
busy  out  1  burst in progress

Behaviour:
- Interface: one clock (aclk); reset asynchronous, active-high (areset).
- Reset values: all outputs 0, except cmd_ready=1 once reset deasserts.
- Reset mid-burst: the in-flight burst is discarded immediately, with no further beats. After release, the block is idle.
- States: IDLE, BURST.
- cmd_ready = (state==IDLE) OR (beat_valid AND beat_ready AND beat_last). This allows back-to-back bursts with no bubble.
- Command handshake = cmd_valid AND cmd_ready. On a legal command, the block registers addr/len/size/burst and enters BURST.
- Latency: beat_valid=1 and beat_idx=0 on the cycle after the handshake, with beat_addr=cmd_addr (unaligned address kept for beat 0).
- Stall: while beat_valid AND NOT beat_ready, beat_addr, beat_idx and beat_last hold stable.
- On each beat handshake: beat_idx increments and beat_addr takes the next value.
- beat_last = (beat_idx == len).
- On the last beat handshake:
  - with no new command: return to IDLE, beat_valid=0 next cycle;
  - with a simultaneous command: the next burst's beat 0 appears next cycle.
- Next address (bytes B = 1<<size, aligned A = addr with low size bits cleared):
  - FIXED: addr unchanged.
  - INCR: A + B, modulo 2^ADDR_W.
  - WRAP: total T = (len+1)*B, boundary W = addr & ~(T-1); next = W | ((A + B) & (T-1)).
- Illegal commands:
  - burst==3;
  - B > DATA_BYTES;
  - WRAP with len not in {1,3,7,15};
  - INCR where (A + (len+1)*B - 1) differs from A in bits [ADDR_W-1:12], or overflows 2^ADDR_W.
- Handling of an illegal command: it is accepted (handshake completes) and produces no beats. cmd_err=1 for exactly one cycle after the handshake, and the state stays or returns to IDLE.
- FIXED commands carry no 4KB check.
- busy = (state==BURST).

Decomposition:
- Package axi_burst_pkg:
  - burst_t enum (FIXED=0, INCR=1, WRAP=2, RSVD=3);
  - constant BOUNDARY_4K=4096;
  - function cmd_legal(addr, len, size, burst).
- Sub-module axi_burst_next_addr: purely combinational next-address computation from (addr, len, size, burst). Reused by the data-path stage.

Test Plan:
- INCR addr=0x1002 len=3 size=2 -> beat_addr 0x1002, 0x1004, 0x1008, 0x100C; beat_last only with idx 3; cmd_ready=0 during beats 0-2.
- WRAP addr=0x1034 len=3 size=2 -> 0x1034, 0x1038, 0x103C, 0x1030; last on 0x1030.
- FIXED addr=0x200 len=2 size=1 -> 0x200 three times, idx 0, 1, 2.
- INCR addr=0x0FF8 len=3 size=2 -> no beat_valid; cmd_err=1 for one cycle; next command accepted the following cycle. Same result for WRAP len=2 and for size=3 with DATA_BYTES=4.
- Backpressure:
  - INCR len=1: hold beat_ready=0 for 3 cycles on beat 0 -> addr, idx and last stable.
  - Second command presented during the last-beat handshake -> accepted that cycle; its beat 0 valid next cycle.
- areset pulsed after beat 1 of an INCR len=7 -> beat_valid and busy fall immediately. After release, INCR addr=0x40 len=0 -> single beat 0x40 with last=1.
